// File: rtl/opc6_io_timer_target.sv
`default_nettype none
// ============================================================================
//  Module      : opc6_io_timer_target
//  Description : OPC6 I/O-space target. It decodes an 8-word register window,
//                stretches each access by IO_WAIT wait states by dropping
//                clken, and provides a prescaled down-counter timer and a
//                software interrupt latch. Interrupts are driven on int_b,
//                which is active low.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                address, wr_data    - CPU address and CPU dout
//                rnw, vio            - read-not-write, I/O cycle valid
//                rd_data             - read data; zero when not selected, so
//                                      it can be OR-ed onto the CPU din bus
//                clken               - CPU clock enable (0 stalls the CPU)
//                int_b[1:0]          - [0] timer, [1] software, active low
//  Revision    : 1.0  initial release
// ============================================================================
module opc6_io_timer_target #(
    parameter logic [15:0] BASE_ADDR = 16'hFE00,
    parameter int unsigned IO_WAIT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] wr_data,
    input  logic        rnw,
    input  logic        vio,
    output logic [15:0] rd_data,
    output logic        clken,
    output logic [1:0]  int_b
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;

    // WAIT is entered after the IDLE stall cycle; the counter holds the
    // number of extra WAIT cycles still to spend before ACK.
    localparam logic [3:0] c_WAIT_LOAD = (IO_WAIT >= 2) ? 4'(IO_WAIT - 2) : 4'd0;

    logic [1:0]  r_state;
    logic [3:0]  r_wcnt;

    logic        r_en;
    logic        r_auto;
    logic        r_tie;
    logic        r_sie;
    logic [7:0]  r_prescale;
    logic        r_exp;
    logic        r_swi;
    logic [15:0] r_reload;
    logic [15:0] r_count;
    logic [7:0]  r_pre;

    logic        w_hit;
    logic        w_commit;
    logic        w_stall;
    logic        w_acc;
    logic        w_wr;
    logic        w_tick;
    logic        w_expire;
    logic [15:0] w_rd;

    assign w_hit = vio & (address[15:3] == BASE_ADDR[15:3]);

    generate
        if (IO_WAIT == 0) begin : g_nowait
            assign w_commit = w_hit;
            assign w_stall  = 1'b0;
        end else begin : g_wait
            assign w_commit = (r_state == c_ST_ACK);
            assign w_stall  = ((r_state == c_ST_IDLE) & w_hit) | (r_state == c_ST_WAIT);
        end
    endgenerate

    // Reset abandons any access in flight and releases the CPU immediately.
    assign w_acc = w_commit & ~reset;
    assign w_wr  = w_acc & ~rnw;
    assign clken = reset | ~w_stall;

    // Access sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_hit && (IO_WAIT != 0)) begin
                        if (IO_WAIT == 1) begin
                            r_state <= c_ST_ACK;
                        end else begin
                            r_state <= c_ST_WAIT;
                            r_wcnt  <= c_WAIT_LOAD;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        r_state <= c_ST_ACK;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                c_ST_ACK: r_state <= c_ST_IDLE;
                default:  r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_tick   = r_en & (r_pre == r_prescale);
    assign w_expire = w_tick & (r_count == 16'd0);

    // Register file and timer. Bus writes take priority over timer updates,
    // except that an expiry beats a same-cycle write-1-to-clear of EXP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_tie      <= 1'b0;
            r_sie      <= 1'b0;
            r_prescale <= 8'd0;
            r_exp      <= 1'b0;
            r_swi      <= 1'b0;
            r_reload   <= 16'd0;
            r_count    <= 16'd0;
            r_pre      <= 8'd0;
        end else begin
            // Only an EN 0->1 write restarts the prescaler phase.
            if (w_wr && (address[2:0] == 3'd0) && wr_data[0] && !r_en) begin
                r_pre <= 8'd0;
            end else if (r_en) begin
                r_pre <= w_tick ? 8'd0 : r_pre + 8'd1;
            end

            if (w_wr && (address[2:0] == 3'd3)) begin
                r_count <= wr_data;
            end else if (w_tick) begin
                if (r_count != 16'd0) begin
                    r_count <= r_count - 16'd1;
                end else if (r_auto) begin
                    r_count <= r_reload;
                end
            end

            if (w_wr && (address[2:0] == 3'd0)) begin
                r_en       <= wr_data[0];
                r_auto     <= wr_data[1];
                r_tie      <= wr_data[2];
                r_sie      <= wr_data[3];
                r_prescale <= wr_data[15:8];
            end else if (w_expire && !r_auto) begin
                r_en <= 1'b0;
            end

            if (w_wr && (address[2:0] == 3'd2)) begin
                r_reload <= wr_data;
            end

            if (w_expire) begin
                r_exp <= 1'b1;
            end else if (w_wr && (address[2:0] == 3'd1) && wr_data[0]) begin
                r_exp <= 1'b0;
            end

            if (w_wr && (address[2:0] == 3'd4)) begin
                r_swi <= 1'b1;
            end else if (w_wr && (address[2:0] == 3'd1) && wr_data[1]) begin
                r_swi <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd = 16'd0;
        if (w_acc && rnw) begin
            case (address[2:0])
                3'd0:    w_rd = {r_prescale, 4'd0, r_sie, r_tie, r_auto, r_en};
                3'd1:    w_rd = {14'd0, r_swi, r_exp};
                3'd2:    w_rd = r_reload;
                3'd3:    w_rd = r_count;
                default: w_rd = 16'd0;
            endcase
        end
    end

    assign rd_data = w_rd;
    assign int_b   = {~(r_swi & r_sie), ~(r_exp & r_tie)};

endmodule
`default_nettype wire

// File: tb/tb_opc6_io_timer_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opc6_io_timer_target
//  Description : Self-checking bench for opc6_io_timer_target with two wait
//                states. A behavioural model of the register file and timer,
//                stepped once per clock, predicts clken, rd_data and int_b
//                for every cycle; directed sequences and random accesses
//                drive the bus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_opc6_io_timer_target;

    localparam logic [15:0] BASE_ADDR = 16'hFE00;
    localparam int          IO_WAIT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic [15:0] wr_data;
    logic        rnw;
    logic        vio;
    logic [15:0] rd_data;
    logic        clken;
    logic [1:0]  int_b;

    opc6_io_timer_target #(
        .BASE_ADDR (BASE_ADDR),
        .IO_WAIT   (IO_WAIT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .wr_data (wr_data),
        .rnw     (rnw),
        .vio     (vio),
        .rd_data (rd_data),
        .clken   (clken),
        .int_b   (int_b)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state
    bit          m_en, m_auto, m_tie, m_sie, m_exp, m_swi;
    logic [7:0]  m_ps;
    logic [15:0] m_reload, m_count;
    int          m_pre;
    int          m_stall;
    logic [15:0] last_rd;

    function automatic logic [15:0] m_read(input logic [2:0] off);
        case (off)
            3'd0:    return {m_ps, 4'd0, m_sie, m_tie, m_auto, m_en};
            3'd1:    return {14'd0, m_swi, m_exp};
            3'd2:    return m_reload;
            3'd3:    return m_count;
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_tie = 0; m_sie = 0; m_exp = 0; m_swi = 0;
        m_ps = 8'd0; m_reload = 16'd0; m_count = 16'd0; m_pre = 0; m_stall = 0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, then advance both DUT and model across the rising edge.
    task automatic cyc(input logic rs, input logic v, input logic r,
                       input logic [15:0] a, input logic [15:0] d, input bit do_chk);
        bit hit_m, com, tick, old_en, set_exp;
        logic [15:0] exp_rd;
        reset = rs; vio = v; rnw = r; address = a; wr_data = d;
        #1;
        hit_m  = v && (a[15:3] == BASE_ADDR[15:3]);
        com    = !rs && hit_m && (m_stall == IO_WAIT);
        exp_rd = (com && r) ? m_read(a[2:0]) : 16'd0;
        if (do_chk) begin
            check("clken", clken, rs || !hit_m || com);
            check("rd_data", rd_data, exp_rd);
            check("int_b", int_b, {!(m_swi && m_sie), !(m_exp && m_tie)});
        end
        last_rd = rd_data;
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            tick    = m_en && (m_pre == int'(m_ps));
            old_en  = m_en;
            set_exp = 0;
            if (m_en) m_pre = tick ? 0 : m_pre + 1;
            if (tick) begin
                if (m_count != 16'd0) m_count = m_count - 16'd1;
                else begin
                    set_exp = 1;
                    if (m_auto) m_count = m_reload;
                    else m_en = 0;
                end
            end
            if (set_exp) m_exp = 1;
            if (com && !r) begin
                case (a[2:0])
                    3'd0: begin
                        if (d[0] && !old_en) m_pre = 0;
                        m_en = d[0]; m_auto = d[1]; m_tie = d[2]; m_sie = d[3]; m_ps = d[15:8];
                    end
                    3'd1: begin
                        if (d[0] && !set_exp) m_exp = 0;
                        if (d[1]) m_swi = 0;
                    end
                    3'd2: m_reload = d;
                    3'd3: m_count = d;
                    3'd4: m_swi = 1;
                    default: ;
                endcase
            end
            if (!hit_m || com) m_stall = 0;
            else m_stall = m_stall + 1;
        end
        #1;
    endtask

    // Complete bus access: the commit cycle is the last one of IO_WAIT+1.
    task automatic acc(input logic r, input logic [2:0] off, input logic [15:0] d,
                       output logic [15:0] q);
        for (int i = 0; i <= IO_WAIT; i++) begin
            cyc(1'b0, 1'b1, r, BASE_ADDR | {13'd0, off}, d, 1'b1);
        end
        q = last_rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, BASE_ADDR, 16'hFFFF, 1'b1);
    endtask

    initial begin
        logic [15:0] q;
        logic [15:0] a;
        logic [15:0] d;
        logic [2:0]  off;
        logic        r;
        int          lat;

        model_reset();
        last_rd = 16'd0;

        // Reset held with a hitting I/O cycle on the bus
        cyc(1'b1, 1'b1, 1'b1, BASE_ADDR | 16'd3, 16'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, BASE_ADDR | 16'd3, 16'd0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, BASE_ADDR | 16'd3, 16'd0, 1'b1);
        acc(1'b1, 3'd3, 16'd0, q);
        check("count_after_reset", q, 16'd0);

        // Wait-stated read back of RELOAD
        acc(1'b0, 3'd2, 16'h1234, q);
        idle(1);
        acc(1'b1, 3'd2, 16'd0, q);
        check("rd_reload", q, 16'h1234);
        idle(1);

        // One-shot expiry
        acc(1'b0, 3'd2, 16'd3, q);
        acc(1'b0, 3'd3, 16'd3, q);
        acc(1'b0, 3'd0, 16'h0105, q);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            idle(1);
            if (lat < 0 && int_b[0] == 1'b0) lat = k;
        end
        check("oneshot_latency", lat, 8);
        acc(1'b1, 3'd0, 16'd0, q);
        check("oneshot_en_clear", q[0], 1'b0);
        acc(1'b0, 3'd1, 16'd1, q);
        check("w1c_exp", int_b[0], 1'b1);

        // Auto-reload, with W1C writes at shifting phases against expiries
        acc(1'b0, 3'd3, 16'd2, q);
        acc(1'b0, 3'd2, 16'd2, q);
        acc(1'b0, 3'd0, 16'h0007, q);
        idle(7);
        for (int j = 0; j < 6; j++) begin
            acc(1'b0, 3'd1, 16'd1, q);
            if (j % 2 == 1) idle(1);
        end

        // Software interrupt
        acc(1'b0, 3'd0, 16'h0008, q);
        acc(1'b0, 3'd1, 16'd3, q);
        acc(1'b0, 3'd4, 16'h5A5A, q);
        check("swi_set", int_b, 2'b01);
        acc(1'b0, 3'd2 - 3'd1, 16'd2, q);
        check("swi_clr", int_b, 2'b11);

        // Decode: vio low at base, non-hit I/O cycle, unused offset
        idle(3);
        cyc(1'b0, 1'b1, 1'b0, 16'hFDF8, 16'hFFFF, 1'b1);
        acc(1'b1, 3'd6, 16'd0, q);
        check("offset6_read", q, 16'd0);

        // Reset in the middle of a stalled write abandons it
        cyc(1'b0, 1'b1, 1'b0, BASE_ADDR | 16'd2, 16'hBEEF, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, BASE_ADDR | 16'd2, 16'hBEEF, 1'b1);
        acc(1'b1, 3'd2, 16'd0, q);
        check("abort_reload", q, 16'd0);

        // Random traffic with the timer running
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 9) < 2) begin
                a = 16'($urandom);
                if (a[15:3] == BASE_ADDR[15:3]) a[15] = ~a[15];
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    if ($urandom_range(0, 1) == 0) cyc(1'b0, 1'b1, 1'($urandom), a, 16'($urandom), 1'b1);
                    else cyc(1'b0, 1'b0, 1'($urandom), BASE_ADDR | 16'($urandom_range(0, 7)), 16'($urandom), 1'b1);
                end
            end else begin
                off = 3'($urandom_range(0, 7));
                r   = 1'($urandom);
                d   = 16'($urandom);
                if (off == 3'd0) d = {6'd0, 2'($urandom_range(0, 3)), 4'd0, 4'($urandom)};
                if (off == 3'd2 || off == 3'd3) d = 16'($urandom_range(0, 6));
                acc(r, off, d, q);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/opc6_io_timer_target.md
Name: opc6_io_timer_target

Overview:
- Bus responder for the OPC6 CPU's I/O space: the target end of its vpa/vda/vio/rnw/address/dout/din/clken/int_b interface.
- Decodes I/O cycles to an 8-word register window and inserts a programmable number of wait states by dropping clken.
- Provides a prescaled down-counter timer and a software-interrupt latch, driving the CPU's active-low int_b lines.
- Sits beside the memory system; its read data is zero when not selected, so it can be OR-ed onto the CPU din bus.

Parameters:
- BASE_ADDR, 16'hFE00: I/O base address; window is BASE_ADDR[15:3], 8 words.
- IO_WAIT, 1: wait states per I/O access to this block (0..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- address  input  16  CPU address.
- wr_data  input  16  CPU dout.
- rnw  input  1  CPU read-not-write.
- vio  input  1  CPU I/O-cycle valid.
- rd_data  output  16  read data to CPU din; 0 when not selected.
- clken  output  1  CPU clock enable; 0 stalls the CPU.
- int_b  output  2  active-low interrupt requests; [0] = timer, [1] = software.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous, active-high.
- Reset values:
  - State IDLE, clken=1, rd_data=0, int_b=2'b11.
  - CTRL, STATUS, RELOAD, COUNT, prescaler all 0.
  - Reset asserted mid-wait abandons the access: no write commits, clken=1 next cycle.
- hit = vio & (address[15:3]==BASE_ADDR[15:3]). Offset = address[2:0].
- Registers:
  - 0 CTRL: [0] EN, [1] AUTO reload, [2] TIE, [3] SIE, [15:8] PRESCALE; [7:4] read 0.
  - 1 STATUS: [0] EXP, [1] SWI. Write-1-to-clear.
  - 2 RELOAD: 16 bits.
  - 3 COUNT: read = live count; write loads count.
  - 4 SWIRQ: any write sets STATUS[1]; reads 0.
  - 5-7: read 0, writes ignored.
- Access FSM, states IDLE / WAIT / ACK:
  - IO_WAIT=0: clken stays 1. The access commits in the cycle hit is seen (IDLE).
  - IO_WAIT>0:
    - IDLE & hit: clken=0; go to WAIT, or straight to ACK if IO_WAIT=1.
    - WAIT: clken=0; count down until IO_WAIT cycles with clken=0 have elapsed, then go to ACK.
    - ACK: clken=1; the access commits; return to IDLE unconditionally.
  - Commit cycle, write (rnw=0): register updated at that clk edge.
  - Commit cycle, read (rnw=1): rd_data = selected register, combinationally from address.
  - rd_data = 0 in every other cycle and on any write.
  - Stall is exactly IO_WAIT clk cycles per access. Non-hit cycles never drop clken.
- Timer:
  - Runs on clk, independent of clken.
  - While EN=1, the prescaler counts 0..PRESCALE, then wraps to 0 with a one-cycle tick.
  - On tick, COUNT!=0: COUNT <= COUNT-1.
  - On tick, COUNT==0: EXP <= 1; if AUTO=1, COUNT <= RELOAD, else EN <= 0.
  - Period with AUTO=1 is (RELOAD+1)*(PRESCALE+1) clk cycles.
  - EN 0->1 via a CTRL write clears the prescaler.
  - EN=0 freezes both the prescaler and COUNT.
- Interrupts, combinational from registers:
  - int_b[0] = !(EXP & TIE).
  - int_b[1] = !(SWI & SIE).
- Simultaneous events:
  - Expiry set and STATUS W1C in the same cycle: set wins, EXP=1.
  - COUNT write and tick in the same cycle: write wins; the prescaler is not disturbed.
  - SWIRQ write and W1C of SWI cannot coincide, since there is one access per cycle.
- Arithmetic: all 16-bit, no saturation. COUNT never decrements below 0; it reloads or stops.

Test Plan:
- Reset: hold reset 2 cycles with vio=1 and hit -> clken=1, int_b=2'b11, rd_data=0. After release, read COUNT -> 0.
- Wait states, IO_WAIT=2: read of offset 2 after writing RELOAD=16'h1234 -> clken low exactly 2 cycles, then 1 cycle high with rd_data=16'h1234; rd_data=0 before and after.
- One-shot:
  - Stimulus: RELOAD=3, COUNT=3, CTRL=16'h0105 (PRESCALE=1, TIE, EN).
  - Required: int_b[0] falls after 8 clk cycles.
  - Required: EN reads 0 afterwards.
  - Required: writing STATUS=1 -> int_b[0]=1 next cycle.
- Auto-reload: RELOAD=2, CTRL=16'h0007 -> EXP sets every 3 cycles. W1C landing on an expiry cycle -> EXP stays 1.
- Software IRQ: CTRL=16'h0008, write SWIRQ -> int_b=2'b01. Write STATUS=2 -> int_b=2'b11.
- Decode and timer freeze:
  - vio=0 with address=BASE_ADDR -> clken stays 1, no register change.
  - Offset 6 read -> rd_data=0.
  - Timer keeps counting while clken=0.
